xdma_c2h_pkt_arbiter: RTL
=========================

// Module: xdma_c2h_pkt_arbiter
// PURPOSE
//  Packet-level arbiter sharing the single XDMA C2H AXI-Stream (512b) between two sources:
//  src0 = perf-monitor RX datapath, src1 = loopback/debug stream. Grant is held from the
//  first beat to tlast, so packets never interleave. Output is registered through a skid
//  buffer for timing at 250 MHz. Per-source packet counters feed the perf-counter ILA.
// PARAMETERS
//  DATA_WIDTH  512  tdata width
//  KEEP_WIDTH  64   tkeep width (DATA_WIDTH/8)
//  USER_WIDTH  1    tuser width
//  CNT_WIDTH   32   width of per-source packet counters
// PORTS
//  CLK              in   1           clock (xdma axi_aclk domain)
//  RST              in   1           reset, synchronous, active-high
//  s{0,1}_axis_tvalid in 1           source beat valid
//  s{0,1}_axis_tready out 1          source beat ready
//  s{0,1}_axis_tdata/tkeep/tuser/tlast in DATA/KEEP/USER/1  source beat payload
//  m_axis_tvalid    out  1           C2H beat valid
//  m_axis_tready    in   1           C2H beat ready
//  m_axis_tdata/tkeep/tuser/tlast out DATA/KEEP/USER/1  C2H payload
//  cfg_src_enable   in   2           bit i=1: source i may win arbitration
//  cfg_fixed_prio   in   1           0: round-robin; 1: src0 strict priority
//  grant_out        out  2           one-hot current grant, 00 when idle
//  pkt_cnt0/1       out  CNT_WIDTH   packets (tlast handshakes) accepted from src0/src1
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer favours src0, grant_out=00, all s_tready=0,
//    m_axis_tvalid=0, skid empty, pkt_cnt0/1=0. Effective the cycle after RST high.
//  - req_i = s_i_tvalid & cfg_src_enable[i]. Enable sampled only at arbitration points.
//  - FSM IDLE/GRANT0/GRANT1. IDLE: if any req, register winner -> GRANTi (1-cycle latency).
//  - Winner: fixed_prio=1 -> src0 if req0 else src1. fixed_prio=0 -> source other than
//    last granted if it requests, else the requesting one.
//  - GRANTi: s_i_tready = skid_in_ready; other source tready=0. Beat transfers when
//    s_i_tvalid & s_i_tready. On tlast transfer: re-arbitrate same cycle (rr pointer
//    updated to i) -> GRANTj next cycle with no bubble, or IDLE if no req.
//  - Disabling a source mid-packet does not abort it; packet completes, then excluded.
//  - Skid buffer: 2-entry, registered outputs; s->m latency 1 cycle; full throughput
//    (1 beat/cycle) under continuous m_tready; payload held stable while
//    m_tvalid & !m_tready (AXIS rule); m_tvalid never drops without handshake.
//  - pkt_cnt_i += 1 on src-side tlast handshake; wraps modulo 2^CNT_WIDTH, no saturation.
//  - tkeep/tuser/tlast pass unmodified; zero-length or tkeep=0 beats forwarded as-is.
//  - RST mid-packet: partial packet is dropped, skid flushed, m_tvalid=0 next cycle;
//    downstream sees truncated packet (documented, accepted).
//  - Source with tvalid but no tlast for ever holds grant (no timeout; by design).
// STRUCTURE
//  - Shared package xdma_udp_pkg: AXIS beat struct {tdata,tkeep,tuser,tlast}, widths
//    (XDMA_AXIS_TDATA_WIDTH=512, TKEEP=64, TUSER=1), arbiter state enum.
//  - One sub-module: axis_skid_buffer (2-entry, parameterized by beat width).
//  - Arbiter FSM, rr pointer, mux and counters in this module.
// TESTING
//  1 src0 only, 4-beat pkt, m_tready=1 -> grant 01 one cycle after tvalid, 4 beats out
//    in order, m_tvalid 1 cycle after each accept, pkt_cnt0=1, grant 00 after.
//  2 both streaming 3-beat pkts, rr mode -> order src0,src1,src0,src1; no idle cycle
//    between packets; 12 beats in 12 cycles after first; pkt_cnt0=pkt_cnt1=2.
//  3 both streaming, cfg_fixed_prio=1 -> only src0 packets out, s1_tready stays 0;
//    drop src0 tvalid -> src1 granted at next arbitration point.
//  4 m_tready random 50% -> output sequence bit-exact vs scoreboard, payload stable
//    while stalled, no lost/duplicated beats, tlast aligned.
//  5 clear cfg_src_enable[0] on beat 2 of 5-beat src0 pkt -> all 5 beats delivered,
//    then src1 granted; src0 not granted while disabled.
//  6 CNT_WIDTH=4, 17 src1 pkts -> pkt_cnt1=1 (wrap); RST on beat 2 of a pkt ->
//    next cycle m_tvalid=0, grant 00, counters 0.

Source files
------------

// File: rtl/xdma_udp_pkg.sv
// Shared AXI-Stream beat layout, widths and arbitration helpers for the XDMA C2H path.
package xdma_udp_pkg;

  localparam int XDMA_AXIS_TDATA_WIDTH = 512;
  localparam int XDMA_AXIS_TKEEP_WIDTH = 64;
  localparam int XDMA_AXIS_TUSER_WIDTH = 1;

  typedef struct packed {
    logic [XDMA_AXIS_TDATA_WIDTH-1:0] tdata;
    logic [XDMA_AXIS_TKEEP_WIDTH-1:0] tkeep;
    logic [XDMA_AXIS_TUSER_WIDTH-1:0] tuser;
    logic                             tlast;
  } axis_beat_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_e;

  // One-hot winner; in round-robin the source that did not go last is favoured.
  function automatic logic [1:0] arb_pick(input logic [1:0] req,
                                          input logic       fixed_prio,
                                          input logic       last_grant);
    logic [1:0] win;
    win = 2'b00;
    if (fixed_prio || last_grant) begin
      if (req[0])      win = 2'b01;
      else if (req[1]) win = 2'b10;
    end else begin
      if (req[1])      win = 2'b10;
      else if (req[0]) win = 2'b01;
    end
    return win;
  endfunction

  function automatic arb_state_e arb_state_of(input logic [1:0] win);
    arb_state_e st;
    st = ARB_IDLE;
    if (win[0])      st = ARB_GRANT0;
    else if (win[1]) st = ARB_GRANT1;
    return st;
  endfunction

endpackage

// File: rtl/xdma_c2h_pkt_arbiter_if.sv
// AXI-Stream bundle used for both source ports and the C2H output of the packet arbiter.
interface xdma_c2h_pkt_arbiter_if
  import xdma_udp_pkg::*;
#(
  parameter int DATA_WIDTH = XDMA_AXIS_TDATA_WIDTH,
  parameter int KEEP_WIDTH = XDMA_AXIS_TKEEP_WIDTH,
  parameter int USER_WIDTH = XDMA_AXIS_TUSER_WIDTH
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tlast;

  modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/xdma_c2h_pkt_arbiter_skid.sv
// Two-entry skid buffer: registered valid/data/ready, one beat per cycle when unstalled.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_fire;

  // Ready comes straight from a flop so it never depends on in_valid.
  assign in_ready  = !skid_valid_q;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_data_d = in_data;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
    if (srst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: rtl/xdma_c2h_pkt_arbiter.sv
// Packet-level two-source arbiter onto the XDMA C2H stream; grant held from first beat to tlast.
module xdma_c2h_pkt_arbiter
  import xdma_udp_pkg::*;
#(
  parameter int DATA_WIDTH = XDMA_AXIS_TDATA_WIDTH,
  parameter int KEEP_WIDTH = XDMA_AXIS_TKEEP_WIDTH,
  parameter int USER_WIDTH = XDMA_AXIS_TUSER_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  xdma_c2h_pkt_arbiter_if.slave   s0_axis,
  xdma_c2h_pkt_arbiter_if.slave   s1_axis,
  xdma_c2h_pkt_arbiter_if.master  m_axis,
  input  logic [1:0]              cfg_src_enable,
  input  logic                    cfg_fixed_prio,
  output logic [1:0]              grant_out,
  output logic [CNT_WIDTH-1:0]    pkt_cnt0,
  output logic [CNT_WIDTH-1:0]    pkt_cnt1
);

  localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

  arb_state_e           state_q, state_d;
  logic                 last_q, last_d;
  logic                 mid_q, mid_d;
  logic [CNT_WIDTH-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_WIDTH-1:0] pkt_cnt1_q, pkt_cnt1_d;

  logic [1:0]           req;
  logic [BEAT_W-1:0]    s0_beat, s1_beat;
  logic                 skid_in_valid, skid_in_ready, skid_out_valid;
  logic [BEAT_W-1:0]    skid_in_data, skid_out_data;

  assign req     = {s1_axis.tvalid & cfg_src_enable[1], s0_axis.tvalid & cfg_src_enable[0]};
  assign s0_beat = {s0_axis.tdata, s0_axis.tkeep, s0_axis.tuser, s0_axis.tlast};
  assign s1_beat = {s1_axis.tdata, s1_axis.tkeep, s1_axis.tuser, s1_axis.tlast};

  // A grant with no beat taken yet is released as soon as its source stops
  // offering data, so a trailing tvalid at tlast cannot park the grant.
  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    mid_d           = mid_q;
    pkt_cnt0_d      = pkt_cnt0_q;
    pkt_cnt1_d      = pkt_cnt1_q;
    grant_out       = 2'b00;
    skid_in_valid   = 1'b0;
    skid_in_data    = s0_beat;
    s0_axis.tready  = 1'b0;
    s1_axis.tready  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        state_d = arb_state_of(arb_pick(req, cfg_fixed_prio, last_q));
      end
      ARB_GRANT0: begin
        grant_out      = 2'b01;
        s0_axis.tready = skid_in_ready;
        skid_in_valid  = s0_axis.tvalid;
        skid_in_data   = s0_beat;
        if (s0_axis.tvalid && skid_in_ready) begin
          if (s0_axis.tlast) begin
            pkt_cnt0_d = pkt_cnt0_q + CNT_WIDTH'(1);
            last_d     = 1'b0;
            mid_d      = 1'b0;
            state_d    = arb_state_of(arb_pick(req, cfg_fixed_prio, 1'b0));
          end else begin
            mid_d = 1'b1;
          end
        end else if (!mid_q && !s0_axis.tvalid) begin
          state_d = arb_state_of(arb_pick(req, cfg_fixed_prio, last_q));
        end
      end
      ARB_GRANT1: begin
        grant_out      = 2'b10;
        s1_axis.tready = skid_in_ready;
        skid_in_valid  = s1_axis.tvalid;
        skid_in_data   = s1_beat;
        if (s1_axis.tvalid && skid_in_ready) begin
          if (s1_axis.tlast) begin
            pkt_cnt1_d = pkt_cnt1_q + CNT_WIDTH'(1);
            last_d     = 1'b1;
            mid_d      = 1'b0;
            state_d    = arb_state_of(arb_pick(req, cfg_fixed_prio, 1'b1));
          end else begin
            mid_d = 1'b1;
          end
        end else if (!mid_q && !s1_axis.tvalid) begin
          state_d = arb_state_of(arb_pick(req, cfg_fixed_prio, last_q));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // last_q resets to src1 so the first round-robin decision favours src0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ARB_IDLE;
      last_q     <= 1'b1;
      mid_q      <= 1'b0;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      mid_q      <= mid_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  axis_skid_buffer #(.WIDTH(BEAT_W)) u_skid (
    .clk       (CLK),
    .srst      (RST),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .in_data   (skid_in_data),
    .out_valid (skid_out_valid),
    .out_ready (m_axis.tready),
    .out_data  (skid_out_data)
  );

  assign m_axis.tvalid = skid_out_valid;
  assign {m_axis.tdata, m_axis.tkeep, m_axis.tuser, m_axis.tlast} = skid_out_data;
  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

endmodule
